syn_lb_byte_bridge: RTL and testbench

SYN_LB_BYTE_BRIDGE -- requirements
Module: syn_lb_byte_bridge

---
 rtl/syn_lb_pkg.sv | 32 +++
 rtl/syn_lb_intf.sv | 30 +++
 rtl/syn_lb_byte_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_syn_lb_byte_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_lb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syn_lb_pkg
// Description : Shared opcodes, status codes and FSM encoding for the
//               byte-stream to local-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package syn_lb_pkg;

    localparam logic [7:0] C_OP_WRITE     = 8'h01;
    localparam logic [7:0] C_OP_READ      = 8'h02;

    localparam logic [7:0] C_STAT_OK      = 8'hA5;
    localparam logic [7:0] C_STAT_BAD_OP  = 8'hE1;
    localparam logic [7:0] C_STAT_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RSP  = 3'd4,
        ST_SEND_STAT = 3'd5,
        ST_SEND_DATA = 3'd6
    } lb_state_e;

    function automatic logic is_known_opcode(input logic [7:0] op);
        return (op == C_OP_WRITE) || (op == C_OP_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syn_lb_intf.sv
`default_nettype none
// ============================================================================
// Module      : syn_lb_intf
// Description : Local-bus interface; the master issues one-cycle rd_en/wr_en
//               strobes and the slave answers with rd_valid/wr_valid.
// Revision    : 1.0 - initial release
// ============================================================================
interface syn_lb_intf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_en, wr_en, addr, wr_data,
        input  wr_valid, rd_valid, rd_data
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data,
        output wr_valid, rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/syn_lb_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : syn_lb_byte_bridge
// Description : Decodes opcode/address/data byte frames into single local-bus
//               accesses and returns a status byte plus read data.
//               Optional SYN_LB_BRIDGE_TIMEOUT_EN aborts unanswered accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_lb_byte_bridge
    import syn_lb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk_ir,
    input  logic       rst_ih,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    syn_lb_intf.master lb_intf
);

    localparam int C_BYTES = DATA_W / 8;
    localparam int C_CNT_W = $clog2(C_BYTES) + 1;

    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
        $error("syn_lb_byte_bridge: DATA_W must be a positive multiple of 8");
    end
    if ((ADDR_W < 1) || (ADDR_W > 8)) begin : g_bad_addr_w
        $error("syn_lb_byte_bridge: ADDR_W must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("syn_lb_byte_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    lb_state_e           r_state;
    lb_state_e           w_state_nxt;
    logic                r_alive;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_addr_sh;
    logic [DATA_W-1:0]   r_wdata_sh;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [7:0]          r_status;
    logic [C_CNT_W-1:0]  r_cnt;

    logic                w_rx_ready;
    logic                w_tx_valid;
    logic [7:0]          w_tx_data;
    logic                w_rx_fire;
    logic                w_tx_fire;
    logic                w_rsp;
    logic                w_last_byte;
    logic                w_tmo_hit;
    logic [DATA_W-1:0]   w_wdata_shift;

    assign w_rx_fire     = rx_valid_i & w_rx_ready;
    assign w_tx_fire     = w_tx_valid & tx_ready_i;
    assign w_rsp         = r_is_write ? lb_intf.wr_valid : lb_intf.rd_valid;
    assign w_last_byte   = (r_cnt == C_CNT_W'(C_BYTES - 1));
    assign w_wdata_shift = DATA_W'({r_wdata_sh, rx_data_i});

`ifdef SYN_LB_BRIDGE_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TMO_W-1:0] r_tmo;

    // Counts WAIT_RSP cycles; fires on the last allowed cycle without a response.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            r_tmo <= '0;
        end else if (r_state == ST_WAIT_RSP) begin
            r_tmo <= r_tmo + C_TMO_W'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = (r_state == ST_WAIT_RSP) && (r_tmo == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        w_tx_valid  = 1'b0;
        w_tx_data   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                w_rx_ready = r_alive;
                if (w_rx_fire) begin
                    w_state_nxt = is_known_opcode(rx_data_i) ? ST_GET_ADDR : ST_SEND_STAT;
                end
            end
            ST_GET_ADDR: begin
                w_rx_ready = 1'b1;
                if (w_rx_fire) begin
                    w_state_nxt = r_is_write ? ST_GET_DATA : ST_ISSUE;
                end
            end
            ST_GET_DATA: begin
                w_rx_ready = 1'b1;
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = w_rsp ? ST_SEND_STAT : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (w_rsp || w_tmo_hit) begin
                    w_state_nxt = ST_SEND_STAT;
                end
            end
            ST_SEND_STAT: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_status;
                if (w_tx_fire) begin
                    w_state_nxt = (!r_is_write && (r_status == C_STAT_OK)) ? ST_SEND_DATA : ST_IDLE;
                end
            end
            ST_SEND_DATA: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_rdata[DATA_W-1 -: 8];
                if (w_tx_fire && w_last_byte) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            r_state    <= ST_IDLE;
            r_alive    <= 1'b0;
            r_is_write <= 1'b0;
            r_addr_sh  <= '0;
            r_wdata_sh <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_status   <= 8'h00;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_write <= (rx_data_i == C_OP_WRITE);
                        r_status   <= C_STAT_BAD_OP;
                    end
                end
                ST_GET_ADDR: begin
                    // Writes stage the address so the bus keeps the previous access stable.
                    if (w_rx_fire) begin
                        r_cnt <= '0;
                        if (r_is_write) begin
                            r_addr_sh <= rx_data_i[ADDR_W-1:0];
                        end else begin
                            r_addr <= rx_data_i[ADDR_W-1:0];
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata_sh <= w_wdata_shift;
                        r_cnt      <= r_cnt + C_CNT_W'(1);
                        if (w_last_byte) begin
                            r_wdata <= w_wdata_shift;
                            r_addr  <= r_addr_sh;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT_RSP: begin
                    if (w_rsp) begin
                        r_status <= C_STAT_OK;
                        if (!r_is_write) begin
                            r_rdata <= lb_intf.rd_data;
                        end
                    end else if (w_tmo_hit) begin
                        r_status <= C_STAT_TIMEOUT;
                    end
                end
                ST_SEND_STAT: begin
                    if (w_tx_fire) begin
                        r_cnt <= '0;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_tx_fire) begin
                        r_rdata <= r_rdata << 8;
                        r_cnt   <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready_o      = w_rx_ready;
    assign tx_valid_o      = w_tx_valid;
    assign tx_data_o       = w_tx_data;
    assign lb_intf.wr_en   = (r_state == ST_ISSUE) &&  r_is_write;
    assign lb_intf.rd_en   = (r_state == ST_ISSUE) && !r_is_write;
    assign lb_intf.addr    = r_addr;
    assign lb_intf.wr_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_syn_lb_byte_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_syn_lb_byte_bridge
// Description : Self-checking bench for syn_lb_byte_bridge (frame table,
//               tx scoreboard, slave model, reset/backpressure/timeout cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_lb_byte_bridge;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;
    localparam int NV     = 9;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        int          lat;
        logic [7:0]  exp_stat;
        bit          exp_issue;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } iss_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;

    int         n_vec = 0;
    int         n_fail = 0;
    int         n_issue = 0;
    int         exp_issue_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] exp_q[$];
    iss_t       iss_q[$];
    vec_t       vecs[NV];

    always #5 clk = ~clk;

    syn_lb_intf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) lb ();

    syn_lb_byte_bridge #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_ir     (clk),
        .rst_ih     (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .lb_intf    (lb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("rst_rd_en",    {31'd0, lb.rd_en}, 32'd0);
        chk("rst_wr_en",    {31'd0, lb.wr_en}, 32'd0);
        chk("rst_addr",     {24'd0, lb.addr},  32'd0);
        chk("rst_wr_data",  lb.wr_data,        32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_fail++;
            $display("FAIL rx_accept_timeout: byte %02h not accepted, required accept within 100 cycles", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || iss_q.size() != 0 || !rx_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_timeout: %0d tx bytes and %0d accesses outstanding, required 0", exp_q.size(), iss_q.size());
            exp_q.delete();
            iss_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        iss_t r;
        r.wr    = (v.op == 8'h01);
        r.addr  = v.addr;
        r.wdata = v.data;
        r.rdata = v.data;
        r.lat   = v.lat;
        exp_q.push_back(v.exp_stat);
        if (v.exp_issue && !r.wr) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(v.data[31-8*i -: 8]);
        end
        send_byte(v.op);
        if (v.exp_issue) begin
            exp_issue_cnt++;
            if (r.wr) begin
                send_byte(v.addr);
                for (int i = 0; i < 4; i++) begin
                    if (i == 3) iss_q.push_back(r);
                    send_byte(v.data[31-8*i -: 8]);
                end
            end else begin
                iss_q.push_back(r);
                send_byte(v.addr);
            end
        end
    endtask

    task automatic drive_rsp(input iss_t r, input logic v);
        if (r.wr) begin
            lb.wr_valid = v;
        end else begin
            lb.rd_valid = v;
            lb.rd_data  = v ? r.rdata : 32'h0;
        end
    endtask

    // tx scoreboard plus stability check while the sink stalls.
    logic [7:0] stall_data = 8'h00;
    bit         stall_prev = 1'b0;
    logic [7:0] mon_exp;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
                chk("tx_data_hold", {24'd0, tx_data}, {24'd0, stall_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, mon_exp});
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    // Local-bus slave: checks each strobe against the expected access, then responds.
    iss_t slv_r;
    always begin
        @(negedge clk);
        #1;
        if (!rst && (lb.rd_en || lb.wr_en)) begin
            n_issue++;
            if (iss_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL issue_unexpected: got rd_en=%0b wr_en=%0b, required no access", lb.rd_en, lb.wr_en);
            end else begin
                slv_r = iss_q.pop_front();
                chk("wr_en", {31'd0, lb.wr_en}, {31'd0, slv_r.wr});
                chk("rd_en", {31'd0, lb.rd_en}, {31'd0, !slv_r.wr});
                chk("addr", {24'd0, lb.addr}, {24'd0, slv_r.addr});
                if (slv_r.wr) chk("wr_data", lb.wr_data, slv_r.wdata);
                if (slv_r.lat == 0) drive_rsp(slv_r, 1'b1);
                @(negedge clk);
                #1;
                chk("en_pulse_width", {30'd0, lb.rd_en, lb.wr_en}, 32'd0);
                if (slv_r.lat == 0) begin
                    drive_rsp(slv_r, 1'b0);
                end else if (slv_r.lat > 0) begin
                    repeat (slv_r.lat - 1) @(negedge clk);
                    drive_rsp(slv_r, 1'b1);
                    @(negedge clk);
                    drive_rsp(slv_r, 1'b0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   n;

        vecs[0] = '{8'h01, 8'h10, 32'hDEADBEEF, 3, 8'hA5, 1'b1};
        vecs[1] = '{8'h02, 8'h20, 32'h12345678, 2, 8'hA5, 1'b1};
        vecs[2] = '{8'h7F, 8'h00, 32'h0,        0, 8'hE1, 1'b0};
        vecs[3] = '{8'h01, 8'hFF, 32'h00000001, 0, 8'hA5, 1'b1};
        vecs[4] = '{8'h02, 8'h00, 32'hFFFFFFFF, 0, 8'hA5, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 32'h0,        0, 8'hE1, 1'b0};
        vecs[6] = '{8'h03, 8'h00, 32'h0,        0, 8'hE1, 1'b0};
        vecs[7] = '{8'h01, 8'h5A, 32'hA5A55A5A, 1, 8'hA5, 1'b1};
        vecs[8] = '{8'h02, 8'h81, 32'hCAFEF00D, 5, 8'hA5, 1'b1};

        lb.wr_valid = 1'b0;
        lb.rd_valid = 1'b0;
        lb.rd_data  = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
            wait_idle();
            if (vecs[i].exp_issue) last_addr = vecs[i].addr;
            chk("addr_hold", {24'd0, lb.addr}, {24'd0, last_addr});
        end

        // Responses outside WAIT_RSP must be ignored.
        lb.wr_valid = 1'b1;
        lb.rd_valid = 1'b1;
        lb.rd_data  = 32'h55AA55AA;
        @(negedge clk);
        lb.wr_valid = 1'b0;
        lb.rd_valid = 1'b0;
        lb.rd_data  = 32'h0;
        repeat (3) @(negedge clk);
        chk("stray_rsp_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("stray_rsp_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Read response with a stalled sink on the status and second bytes.
        tx_ready = 1'b0;
        rv = '{8'h02, 8'h44, 32'h12345678, 1, 8'hA5, 1'b1};
        run_vec(rv);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_tx_valid_seen", {31'd0, tx_valid}, 32'd1);
        repeat (10) @(negedge clk);
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        repeat (10) @(negedge clk);
        tx_ready = 1'b1;
        wait_idle();
        last_addr = 8'h44;

        // Reset in the middle of a write frame, then a complete write.
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        rv = '{8'h01, 8'h10, 32'hDEADBEEF, 2, 8'hA5, 1'b1};
        run_vec(rv);
        wait_idle();
        chk("post_rst_addr", {24'd0, lb.addr}, 32'h10);
        chk("post_rst_wr_data", lb.wr_data, 32'hDEADBEEF);

`ifdef SYN_LB_BRIDGE_TIMEOUT_EN
        // Silent slave: status 0xEE after TMO waiting cycles, late response ignored.
        begin
            iss_t tr;
            tr.wr    = 1'b0;
            tr.addr  = 8'h33;
            tr.wdata = 32'h0;
            tr.rdata = 32'h0;
            tr.lat   = -1;
            iss_q.push_back(tr);
            exp_issue_cnt++;
            exp_q.push_back(8'hEE);
            send_byte(8'h02);
            send_byte(8'h33);
            n = 0;
            while (!tx_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            n_vec++;
            if (n < TMO || n > TMO + 1) begin
                n_fail++;
                $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d", n, TMO, TMO + 1);
            end
            wait_idle();
            lb.rd_valid = 1'b1;
            lb.rd_data  = 32'h87654321;
            @(negedge clk);
            lb.rd_valid = 1'b0;
            lb.rd_data  = 32'h0;
            repeat (5) @(negedge clk);
            chk("late_rsp_tx_valid", {31'd0, tx_valid}, 32'd0);
        end
`endif

        chk("issue_count", n_issue, exp_issue_cnt);
        chk("tx_queue_empty", exp_q.size(), 32'd0);
        chk("issue_queue_empty", iss_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
